mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-to-one AXI-lite arbiter that shares one memory/peripheral port between the core's instruction-fetch read master (S0) and its data load/store master (S1). It sits between the core's IMEM and HOST buses and a single-ported memory, so that instruction fetch and load/store traffic can target one unified memory. The arbiter serialises traffic: exactly one transaction (S0 read, S1 read or S1 write) is outstanding at a time. Responses are routed back to the granted master.

## Interface
- AXI_AWIDTH, 4, address width of all channels
- AXI_DWIDTH, 32, data width; strobe width is AXI_DWIDTH/8
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- S0_ARADDR/ARVALID/ARREADY  in/in/out  AXI_AWIDTH/1/1  instruction-fetch read address
- S0_RDATA/RRESP/RVALID/RREADY  out/out/out/in  AXI_DWIDTH/2/1/1  instruction-fetch read data
- S1_AWADDR/AWVALID/AWREADY  in/in/out  AXI_AWIDTH/1/1  data write address
- S1_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  AXI_DWIDTH/AXI_DWIDTH/8/1/1  data write data
- S1_BRESP/BVALID/BREADY  out/out/in  2/1/1  data write response
- S1_ARADDR/ARVALID/ARREADY, S1_RDATA/RRESP/RVALID/RREADY  as S0  data read channels
- M_AW*, M_W*, M_B*, M_AR*, M_R*  mirror directions  same widths  shared memory port (arbiter is master)

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- Requests in IDLE:
  - S0 read: S0_ARVALID.
  - S1 request: S1_ARVALID, or S1_AWVALID && S1_WVALID.
  - S1 write has priority over an S1 read. An S1 AWVALID without WVALID (or the reverse) is not a request.
- Grant in IDLE:
  - The granted slave's ready signals (ARREADY, or AWREADY+WREADY together) are high for that single cycle.
  - Address, data and strobe are latched, and the grant id is recorded.
  - Next state is RD_ADDR for a read or WR_REQ for a write.
- RD_ADDR: M_ARVALID=1 with the latched address. On M_ARREADY, go to RD_DATA.
- RD_DATA:
  - M_RDATA and M_RRESP are forwarded combinationally to the granted slave.
  - Granted slave RVALID = M_RVALID. M_RREADY = granted slave RREADY.
  - The other slave's RVALID is 0.
  - On handshake, go to IDLE.
- WR_REQ:
  - M_AWVALID and M_WVALID assert together. Each drops independently after its own handshake; done flags aw_done and w_done track this.
  - When both are done, go to WR_RESP.
- WR_RESP: B channel forwarded S1↔M the same way as R. On BVALID && BREADY, go to IDLE.
- RRESP and BRESP (including SLVERR/DECERR) pass through unchanged. The arbiter never generates a response itself.
- All ready/valid outputs not named above are 0.

## Timing
- Reset: all valid and ready outputs are 0, state = IDLE, aw_done = w_done = 0, last_grant = S1. Data and address outputs are 0.
- RST asserted mid-transaction: the next state is IDLE and the transaction is dropped. Master and memory share the same reset.
- Slave AR accepted in cycle N → M_ARVALID high from cycle N+1.
- Response handshake in cycle N → IDLE in N+1, next grant possible in N+1. There is one bubble cycle between back-to-back transactions.
- Minimum read latency, slave AR to slave RVALID, is 2 cycles when memory ARREADY and RVALID are each 1-cycle.
- M_*VALID, once raised, stays high with stable payload until its handshake.
- Requests arriving while not IDLE are held off: slave ready stays 0. Slaves keep their VALID asserted per AXI rules.

## Configuration
- ARB_RR_EN defined:
  - When S0 and S1 both request in IDLE, the grant goes to the master not in last_grant. last_grant updates on every grant.
  - After reset, S0 wins the first tie.
- ARB_RR_EN undefined: fixed priority, S1 always wins ties. last_grant is not implemented.

## Test plan
- S0 read only, ARADDR=0x4, memory returns 0x00000013 with OKAY → S0_RVALID with 0x00000013 two cycles after the S0 AR handshake; S1 RVALID stays 0.
- S1 write AWADDR=0x8, WDATA=0xDEADBEEF, WSTRB=0xF, memory AWREADY one cycle after WREADY → one M_AW and one M_W handshake; S1_BVALID with BRESP=00; memory word 0x8 = 0xDEADBEEF.
- S0 and S1 reads both asserted every cycle for 4 transactions:
  - ARB_RR_EN on: grant order S0,S1,S0,S1.
  - ARB_RR_EN off: grant order S1,S1,S1,S1 with S0 starved.
- S1 read while memory returns RRESP=2'b10 → S1_RRESP=2'b10 and S0 unaffected.
- Slave RREADY held low 3 cycles during RD_DATA → M_RREADY low for those 3 cycles; data stable; single handshake.
- RST pulsed in RD_DATA → next cycle IDLE with all valids and readies 0; a fresh S0 read afterwards completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-to-one AXI-lite arbiter: instruction fetch (S0) and load/store (S1) share one memory port.
// Define ARB_RR_EN for round-robin tie breaking; otherwise S1 wins every tie.
module mem_port_arbiter #(
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [AXI_AWIDTH-1:0]   i_s0_araddr,
    input  logic                    i_s0_arvalid,
    output logic                    o_s0_arready,
    output logic [AXI_DWIDTH-1:0]   o_s0_rdata,
    output logic [1:0]              o_s0_rresp,
    output logic                    o_s0_rvalid,
    input  logic                    i_s0_rready,
    input  logic [AXI_AWIDTH-1:0]   i_s1_awaddr,
    input  logic                    i_s1_awvalid,
    output logic                    o_s1_awready,
    input  logic [AXI_DWIDTH-1:0]   i_s1_wdata,
    input  logic [AXI_DWIDTH/8-1:0] i_s1_wstrb,
    input  logic                    i_s1_wvalid,
    output logic                    o_s1_wready,
    output logic [1:0]              o_s1_bresp,
    output logic                    o_s1_bvalid,
    input  logic                    i_s1_bready,
    input  logic [AXI_AWIDTH-1:0]   i_s1_araddr,
    input  logic                    i_s1_arvalid,
    output logic                    o_s1_arready,
    output logic [AXI_DWIDTH-1:0]   o_s1_rdata,
    output logic [1:0]              o_s1_rresp,
    output logic                    o_s1_rvalid,
    input  logic                    i_s1_rready,
    output logic [AXI_AWIDTH-1:0]   o_m_awaddr,
    output logic                    o_m_awvalid,
    input  logic                    i_m_awready,
    output logic [AXI_DWIDTH-1:0]   o_m_wdata,
    output logic [AXI_DWIDTH/8-1:0] o_m_wstrb,
    output logic                    o_m_wvalid,
    input  logic                    i_m_wready,
    input  logic [1:0]              i_m_bresp,
    input  logic                    i_m_bvalid,
    output logic                    o_m_bready,
    output logic [AXI_AWIDTH-1:0]   o_m_araddr,
    output logic                    o_m_arvalid,
    input  logic                    i_m_arready,
    input  logic [AXI_DWIDTH-1:0]   i_m_rdata,
    input  logic [1:0]              i_m_rresp,
    input  logic                    i_m_rvalid,
    output logic                    o_m_rready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [AXI_AWIDTH-1:0]   r_addr;
    logic [AXI_DWIDTH-1:0]   r_wdata;
    logic [AXI_DWIDTH/8-1:0] r_wstrb;
    logic                    r_grant_s1;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    w_s0_req;
    logic                    w_s1_wr;
    logic                    w_s1_req;
    logic                    w_pick_s1;

    assign w_s0_req = i_s0_arvalid;
    assign w_s1_wr  = i_s1_awvalid && i_s1_wvalid;
    assign w_s1_req = i_s1_arvalid || w_s1_wr;

`ifdef ARB_RR_EN
    logic r_last_s1;

    // On a tie the master that did not win last time is served.
    assign w_pick_s1 = w_s1_req && (!w_s0_req || !r_last_s1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_s1 <= 1'b1;
        end else if (r_state == IDLE && w_next_state != IDLE) begin
            r_last_s1 <= w_pick_s1;
        end
    end
`else
    assign w_pick_s1 = w_s1_req;
`endif

    assign o_m_araddr = r_addr;
    assign o_m_awaddr = r_addr;
    assign o_m_wdata  = r_wdata;
    assign o_m_wstrb  = r_wstrb;

    always_comb begin
        w_next_state = r_state;
        o_s0_arready = 1'b0;
        o_s1_arready = 1'b0;
        o_s1_awready = 1'b0;
        o_s1_wready  = 1'b0;
        o_s0_rvalid  = 1'b0;
        o_s1_rvalid  = 1'b0;
        o_s1_bvalid  = 1'b0;
        o_m_arvalid  = 1'b0;
        o_m_awvalid  = 1'b0;
        o_m_wvalid   = 1'b0;
        o_m_rready   = 1'b0;
        o_m_bready   = 1'b0;
        case (r_state)
            IDLE: begin
                // Grants are suppressed while reset is held so no ready escapes during reset.
                if (!i_rst && (w_s0_req || w_s1_req)) begin
                    if (w_pick_s1 && w_s1_wr) begin
                        o_s1_awready = 1'b1;
                        o_s1_wready  = 1'b1;
                        w_next_state = WR_REQ;
                    end else if (w_pick_s1) begin
                        o_s1_arready = 1'b1;
                        w_next_state = RD_ADDR;
                    end else begin
                        o_s0_arready = 1'b1;
                        w_next_state = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                o_m_arvalid = 1'b1;
                if (i_m_arready) w_next_state = RD_DATA;
            end
            RD_DATA: begin
                o_s0_rvalid = !r_grant_s1 && i_m_rvalid;
                o_s1_rvalid = r_grant_s1 && i_m_rvalid;
                o_m_rready  = r_grant_s1 ? i_s1_rready : i_s0_rready;
                if (i_m_rvalid && (r_grant_s1 ? i_s1_rready : i_s0_rready)) w_next_state = IDLE;
            end
            WR_REQ: begin
                o_m_awvalid = !r_aw_done;
                o_m_wvalid  = !r_w_done;
                if ((r_aw_done || i_m_awready) && (r_w_done || i_m_wready)) w_next_state = WR_RESP;
            end
            WR_RESP: begin
                o_s1_bvalid = i_m_bvalid;
                o_m_bready  = i_s1_bready;
                if (i_m_bvalid && i_s1_bready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_s0_rdata = '0;
        o_s0_rresp = '0;
        o_s1_rdata = '0;
        o_s1_rresp = '0;
        o_s1_bresp = '0;
        if (r_state == RD_DATA && !r_grant_s1) begin
            o_s0_rdata = i_m_rdata;
            o_s0_rresp = i_m_rresp;
        end
        if (r_state == RD_DATA && r_grant_s1) begin
            o_s1_rdata = i_m_rdata;
            o_s1_rresp = i_m_rresp;
        end
        if (r_state == WR_RESP) o_s1_bresp = i_m_bresp;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_grant_s1 <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_next_state != IDLE) begin
                r_grant_s1 <= w_pick_s1;
                if (w_pick_s1 && w_s1_wr) begin
                    r_addr  <= i_s1_awaddr;
                    r_wdata <= i_s1_wdata;
                    r_wstrb <= i_s1_wstrb;
                end else if (w_pick_s1) begin
                    r_addr <= i_s1_araddr;
                end else begin
                    r_addr <= i_s0_araddr;
                end
            end
            // Each write channel drops independently once its own handshake is done.
            if (r_state == WR_REQ) begin
                if (w_next_state == WR_RESP) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    if (o_m_awvalid && i_m_awready) r_aw_done <= 1'b1;
                    if (o_m_wvalid && i_m_wready)   r_w_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small single-ported memory model.
// Tie-break expectations follow ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  s0Araddr;
    logic        s0Arvalid, s0Arready;
    logic [31:0] s0Rdata;
    logic [1:0]  s0Rresp;
    logic        s0Rvalid, s0Rready;
    logic [3:0]  s1Awaddr;
    logic        s1Awvalid, s1Awready;
    logic [31:0] s1Wdata;
    logic [3:0]  s1Wstrb;
    logic        s1Wvalid, s1Wready;
    logic [1:0]  s1Bresp;
    logic        s1Bvalid, s1Bready;
    logic [3:0]  s1Araddr;
    logic        s1Arvalid, s1Arready;
    logic [31:0] s1Rdata;
    logic [1:0]  s1Rresp;
    logic        s1Rvalid, s1Rready;
    logic [3:0]  mAwaddr;
    logic        mAwvalid, mAwready;
    logic [31:0] mWdata;
    logic [3:0]  mWstrb;
    logic        mWvalid, mWready;
    logic [1:0]  mBresp;
    logic        mBvalid, mBready;
    logic [3:0]  mAraddr;
    logic        mArvalid, mArready;
    logic [31:0] mRdata;
    logic [1:0]  mRresp;
    logic        mRvalid, mRready;

    mem_port_arbiter #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) dut (
        .i_clk(clock), .i_rst(reset),
        .i_s0_araddr(s0Araddr), .i_s0_arvalid(s0Arvalid), .o_s0_arready(s0Arready),
        .o_s0_rdata(s0Rdata), .o_s0_rresp(s0Rresp), .o_s0_rvalid(s0Rvalid), .i_s0_rready(s0Rready),
        .i_s1_awaddr(s1Awaddr), .i_s1_awvalid(s1Awvalid), .o_s1_awready(s1Awready),
        .i_s1_wdata(s1Wdata), .i_s1_wstrb(s1Wstrb), .i_s1_wvalid(s1Wvalid), .o_s1_wready(s1Wready),
        .o_s1_bresp(s1Bresp), .o_s1_bvalid(s1Bvalid), .i_s1_bready(s1Bready),
        .i_s1_araddr(s1Araddr), .i_s1_arvalid(s1Arvalid), .o_s1_arready(s1Arready),
        .o_s1_rdata(s1Rdata), .o_s1_rresp(s1Rresp), .o_s1_rvalid(s1Rvalid), .i_s1_rready(s1Rready),
        .o_m_awaddr(mAwaddr), .o_m_awvalid(mAwvalid), .i_m_awready(mAwready),
        .o_m_wdata(mWdata), .o_m_wstrb(mWstrb), .o_m_wvalid(mWvalid), .i_m_wready(mWready),
        .i_m_bresp(mBresp), .i_m_bvalid(mBvalid), .o_m_bready(mBready),
        .o_m_araddr(mAraddr), .o_m_arvalid(mArvalid), .i_m_arready(mArready),
        .i_m_rdata(mRdata), .i_m_rresp(mRresp), .i_m_rvalid(mRvalid), .o_m_rready(mRready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] memInit(input int idx);
        return (idx == 4) ? 32'h0000_0013 : (32'hC0DE_0000 | 32'(idx));
    endfunction

    // Memory model: ARREADY always high, RVALID one cycle after AR, AWREADY one cycle after the W handshake.
    logic [31:0] memArray [16];
    logic        memRvalid, memWSeen, memBvalid;
    logic [31:0] memRdata, memWdata;
    logic [1:0]  memRresp, forceRresp;
    logic [3:0]  memWstrb;
    int          awHsCount, wHsCount, rHsCount;

    assign mArready = 1'b1;
    assign mWready  = !memWSeen;
    assign mAwready = memWSeen;
    assign mRvalid  = memRvalid;
    assign mRdata   = memRdata;
    assign mRresp   = memRresp;
    assign mBvalid  = memBvalid;
    assign mBresp   = 2'b00;

    always @(posedge clock) begin
        if (reset) begin
            memRvalid <= 1'b0;
            memRdata  <= '0;
            memRresp  <= '0;
            memWSeen  <= 1'b0;
            memWdata  <= '0;
            memWstrb  <= '0;
            memBvalid <= 1'b0;
            for (int i = 0; i < 16; i++) memArray[i] <= memInit(i);
        end else begin
            if (mArvalid && mArready) begin
                memRvalid <= 1'b1;
                memRdata  <= memArray[mAraddr];
                memRresp  <= forceRresp;
            end else if (memRvalid && mRready) begin
                memRvalid <= 1'b0;
            end
            if (mWvalid && mWready) begin
                memWSeen <= 1'b1;
                memWdata <= mWdata;
                memWstrb <= mWstrb;
            end
            if (mAwvalid && mAwready) begin
                for (int b = 0; b < 4; b++)
                    if (memWstrb[b]) memArray[mAwaddr][b*8 +: 8] <= memWdata[b*8 +: 8];
                memWSeen  <= 1'b0;
                memBvalid <= 1'b1;
            end else if (memBvalid && mBready) begin
                memBvalid <= 1'b0;
            end
        end
    end

    initial begin
        awHsCount = 0;
        wHsCount  = 0;
        rHsCount  = 0;
    end

    always @(posedge clock) begin
        if (mAwvalid && mAwready) awHsCount <= awHsCount + 1;
        if (mWvalid && mWready)   wHsCount  <= wHsCount + 1;
        if (mRvalid && mRready)   rHsCount  <= rHsCount + 1;
    end

    typedef struct packed {
        logic       s0Ar;
        logic       s1Ar;
        logic       s1Aw;
        logic       s1W;
        logic [3:0] expReady;
    } Vector;

    Vector vectors [11];
    int    compareCount;
    int    failCount;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        s0Arvalid = 1'b0;
        s1Arvalid = 1'b0;
        s1Awvalid = 1'b0;
        s1Wvalid  = 1'b0;
        s0Rready  = 1'b1;
        s1Rready  = 1'b1;
        s1Bready  = 1'b1;
    endtask

    task automatic applyStimulus(input Vector v);
        s0Araddr  = 4'h1;
        s1Araddr  = 4'h2;
        s1Awaddr  = 4'h5;
        s1Wdata   = 32'h1111_2222;
        s1Wstrb   = 4'hF;
        s0Arvalid = v.s0Ar;
        s1Arvalid = v.s1Ar;
        s1Awvalid = v.s1Aw;
        s1Wvalid  = v.s1W;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        idleInputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [11:0] handshakeBits();
        return {s0Arready, s1Arready, s1Awready, s1Wready, mArvalid, mAwvalid, mWvalid,
                mRready, mBready, s0Rvalid, s1Rvalid, s1Bvalid};
    endfunction

    // Issues a single S0 read and waits (bounded) for its response to appear.
    task automatic issueS0Read(input logic [3:0] addr, output logic seen);
        seen = 1'b0;
        @(negedge clock);
        s0Araddr  = addr;
        s0Arvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        s0Arvalid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (s0Rvalid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    logic        seen, s0Seen;
    int          awBefore, wBefore, rBefore;
    int          nGrants;
    int          grantOrder [4];
    int          expOrder [4];

    initial begin
        compareCount = 0;
        failCount    = 0;
        forceRresp   = 2'b00;
        s0Araddr = '0; s1Araddr = '0; s1Awaddr = '0; s1Wdata = '0; s1Wstrb = '0;
        idleInputs();
        reset = 1'b1;

        vectors[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vectors[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0000};
        vectors[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
        vectors[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1000};
        vectors[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0100};
        vectors[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'b0011};
        vectors[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b0011};
`ifdef ARB_RR_EN
        vectors[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1000};
        vectors[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1000};
        expOrder = '{0, 1, 0, 1};
`else
        vectors[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0100};
        vectors[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0100};
        expOrder = '{1, 1, 1, 1};
`endif
        vectors[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0011};
        vectors[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b1000};

        // Requests held during reset must not be granted.
        @(negedge clock);
        s0Arvalid = 1'b1; s1Awvalid = 1'b1; s1Wvalid = 1'b1;
        #2;
        checkOutput("reset handshakes", 32'(handshakeBits()), 32'h0);
        checkOutput("reset m_araddr", 32'(mAraddr), 32'h0);
        checkOutput("reset m_wdata", mWdata, 32'h0);
        checkOutput("reset s0_rdata", s0Rdata, 32'h0);
        idleInputs();
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            applyStimulus(vectors[i]);
            #2;
            checkOutput($sformatf("vec%0d ready", i),
                        32'({s0Arready, s1Arready, s1Awready, s1Wready}), 32'(vectors[i].expReady));
            @(posedge clock);
            @(negedge clock);
            idleInputs();
            repeat (6) @(negedge clock);
        end

        // S0 read: address forwarded next cycle, data two cycles after the AR handshake.
        @(negedge clock);
        s0Araddr  = 4'h4;
        s0Arvalid = 1'b1;
        #2;
        checkOutput("seqA s0 arready", 32'(s0Arready), 32'h1);
        @(posedge clock);
        @(negedge clock);
        s0Arvalid = 1'b0;
        #1;
        checkOutput("seqA m_arvalid", 32'(mArvalid), 32'h1);
        checkOutput("seqA m_araddr", 32'(mAraddr), 32'h4);
        checkOutput("seqA early rvalid", 32'(s0Rvalid), 32'h0);
        @(negedge clock);
        #1;
        checkOutput("seqA s0 rvalid", 32'(s0Rvalid), 32'h1);
        checkOutput("seqA s0 rdata", s0Rdata, 32'h0000_0013);
        checkOutput("seqA s0 rresp", 32'(s0Rresp), 32'h0);
        checkOutput("seqA s1 rvalid", 32'(s1Rvalid), 32'h0);
        @(negedge clock);
        #1;
        checkOutput("seqA rvalid dropped", 32'(s0Rvalid), 32'h0);
        repeat (2) @(negedge clock);

        // S1 write with memory AWREADY lagging WREADY by one cycle.
        awBefore = awHsCount;
        wBefore  = wHsCount;
        @(negedge clock);
        s1Awaddr  = 4'h8;
        s1Wdata   = 32'hDEAD_BEEF;
        s1Wstrb   = 4'hF;
        s1Awvalid = 1'b1;
        s1Wvalid  = 1'b1;
        #2;
        checkOutput("seqB aw/w ready", 32'({s1Awready, s1Wready}), 32'h3);
        @(posedge clock);
        @(negedge clock);
        idleInputs();
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (s1Bvalid) begin
                seen = 1'b1;
                checkOutput("seqB bresp", 32'(s1Bresp), 32'h0);
                break;
            end
            @(negedge clock);
        end
        checkOutput("seqB bvalid seen", 32'(seen), 32'h1);
        repeat (2) @(negedge clock);
        checkOutput("seqB aw handshakes", 32'(awHsCount - awBefore), 32'h1);
        checkOutput("seqB w handshakes", 32'(wHsCount - wBefore), 32'h1);
        checkOutput("seqB mem[8]", memArray[8], 32'hDEAD_BEEF);

        // S1 read with SLVERR passes the error through and leaves S0 quiet.
        forceRresp = 2'b10;
        @(negedge clock);
        s1Araddr  = 4'h3;
        s1Arvalid = 1'b1;
        #2;
        checkOutput("seqD s1 arready", 32'(s1Arready), 32'h1);
        @(posedge clock);
        @(negedge clock);
        s1Arvalid = 1'b0;
        seen   = 1'b0;
        s0Seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (s0Rvalid) s0Seen = 1'b1;
            if (s1Rvalid) begin
                seen = 1'b1;
                checkOutput("seqD s1 rresp", 32'(s1Rresp), 32'h2);
                checkOutput("seqD s1 rdata", s1Rdata, memInit(3));
                break;
            end
            @(negedge clock);
        end
        checkOutput("seqD s1 rvalid seen", 32'(seen), 32'h1);
        checkOutput("seqD s0 rvalid", 32'(s0Seen), 32'h0);
        forceRresp = 2'b00;
        repeat (2) @(negedge clock);

        // Slave back-pressure: RREADY low for three cycles while data is presented.
        s0Rready = 1'b0;
        issueS0Read(4'h6, seen);
        checkOutput("seqE rvalid seen", 32'(seen), 32'h1);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("seqE m_rready c%0d", k), 32'(mRready), 32'h0);
            checkOutput($sformatf("seqE rdata c%0d", k), s0Rdata, memInit(6));
            checkOutput($sformatf("seqE rvalid c%0d", k), 32'(s0Rvalid), 32'h1);
            @(negedge clock);
        end
        rBefore  = rHsCount;
        s0Rready = 1'b1;
        #1;
        checkOutput("seqE m_rready high", 32'(mRready), 32'h1);
        @(negedge clock);
        #1;
        checkOutput("seqE single handshake", 32'(rHsCount - rBefore), 32'h1);
        checkOutput("seqE rvalid dropped", 32'(s0Rvalid), 32'h0);
        repeat (2) @(negedge clock);

        // Reset while data is pending drops the read; a fresh read then completes.
        s0Rready = 1'b0;
        issueS0Read(4'h7, seen);
        checkOutput("seqF in RD_DATA", 32'(seen), 32'h1);
        reset    = 1'b1;
        s0Rready = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("seqF post-reset handshakes", 32'(handshakeBits()), 32'h0);
        issueS0Read(4'h4, seen);
        checkOutput("seqF fresh rvalid", 32'(seen), 32'h1);
        checkOutput("seqF fresh rdata", s0Rdata, 32'h0000_0013);
        repeat (3) @(negedge clock);

        // Both masters read continuously: record four grants in order.
        doReset();
        @(negedge clock);
        s0Araddr  = 4'h1;
        s1Araddr  = 4'h2;
        s0Arvalid = 1'b1;
        s1Arvalid = 1'b1;
        nGrants   = 0;
        for (int c = 0; c < 60 && nGrants < 4; c++) begin
            #1;
            if (s0Arready && s1Arready) begin
                grantOrder[nGrants] = 2;
                nGrants++;
            end else if (s0Arready) begin
                grantOrder[nGrants] = 0;
                nGrants++;
            end else if (s1Arready) begin
                grantOrder[nGrants] = 1;
                nGrants++;
            end
            @(negedge clock);
        end
        idleInputs();
        checkOutput("seqC grant count", 32'(nGrants), 32'h4);
        for (int g = 0; g < nGrants; g++)
            checkOutput($sformatf("seqC grant%0d", g), 32'(grantOrder[g]), 32'(expOrder[g]));
        repeat (6) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
